fetch_prefetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next CPU generation. It replaces the fixed single-word fetch state with a decoupled fetcher.
- Generates sequential PCs and runs a req/ack memory handshake with arbitrary wait states.
- Buffers fetched words, each with its PC, in a DEPTH-entry first-word-fall-through queue feeding the decode/control stage over a valid/ready interface.
- Supports redirect (branch/jump) with flush and discard of an in-flight response.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/prefetch_fifo.sv | 65 ++++++
 rtl/fetch_prefetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
//   fetch_state_e  : fetcher FSM states (IDLE / REQ / DROP)
//   CNT_W()        : width of an occupancy counter able to hold 0..depth
//   fetch_entry_t  : {pc, word} queue entry at the default 32/32 widths;
//                    the top builds the same shape at its configured widths
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_DATA_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_DATA_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// First-word-fall-through synchronous FIFO with flush.
//   clk, rst      : clock, asynchronous active-low reset
//   flush_i       : empties the queue at the edge; overrides push/pop
//   push_i/wdata_i: write an entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   rdata_o       : head entry, zero when empty
//   count_o       : occupied entries; full_o / empty_o status flags
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic [CNT_W(DEPTH)-1:0] count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = CNT_W(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers are log2(DEPTH) bits wide and wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; the head is only exposed when count is nonzero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Decoupled instruction fetcher: sequential PC generation, req/ack memory
// handshake with arbitrary wait states, and a DEPTH-entry FWFT queue of
// {pc, word} feeding decode over valid/ready.
//   clk, rst                 : clock, asynchronous active-low reset
//   mem_req/mem_addr         : fetch request, held (address stable) until ack
//   mem_ack/mem_rdata        : response strobe and word, sampled while mem_req
//   redirect/redirect_pc     : flush queue and restart fetch at redirect_pc
//   ins_valid/ins_ready      : head-of-queue handshake
//   instruction/ins_pc       : head word and its PC, zero when empty
//   fifo_count               : occupied queue entries
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    ins_valid,
  input  logic                    ins_ready,
  output logic [DATA_W-1:0]       instruction,
  output logic [ADDR_W-1:0]       ins_pc,
  output logic [CNT_W(DEPTH)-1:0] fifo_count
);

  localparam int CW = CNT_W(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] word;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] pc_next;

  entry_t            wr_entry;
  entry_t            rd_entry;
  logic              q_push;
  logic              q_pop;
  logic              q_flush;
  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  logic [CW:0]       occ_after;

  prefetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (q_flush),
    .push_i  (q_push),
    .wdata_i (wr_entry),
    .pop_i   (q_pop),
    .rdata_o (rd_entry),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign q_pop   = ins_ready & ~q_empty;
  assign q_flush = redirect;
  assign pc_next = fetch_pc_q + ADDR_W'(PC_STEP);

  // Occupancy after this cycle's push and any concurrent pop; decides whether
  // the next request can be issued back-to-back.
  assign occ_after = {1'b0, q_count} + (CW+1)'(1) - (CW+1)'(q_pop);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    q_push        = 1'b0;
    wr_entry.pc   = mem_addr_q;
    wr_entry.word = mem_rdata;

    if (redirect) fetch_pc_d = redirect_pc;

    unique case (state_q)
      IDLE: begin
        // No word is ever outstanding here, so space is just "not full".
        if (!redirect && !q_full) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (redirect) begin
            // Response belongs to the old stream: discard it.
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end else begin
            q_push     = 1'b1;
            fetch_pc_d = pc_next;
            if (occ_after < (CW+1)'(DEPTH)) begin
              mem_addr_d = pc_next;
            end else begin
              state_d   = IDLE;
              mem_req_d = 1'b0;
            end
          end
        end else if (redirect) begin
          // Handshake cannot be abandoned: keep requesting the old address
          // and throw its data away when it finally arrives.
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign ins_valid   = ~q_empty;
  assign instruction = rd_entry.word;
  assign ins_pc      = rd_entry.pc;
  assign fifo_count  = q_count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] instruction;
  logic [31:0] ins_pc;
  logic [2:0]  fifo_count;

  logic        w_mem_req;
  logic [31:0] w_mem_addr;
  logic        w_mem_ack;
  logic [31:0] w_mem_rdata;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_ins_valid;
  logic        w_ins_ready;
  logic [31:0] w_instruction;
  logic [31:0] w_ins_pc;
  logic [2:0]  w_fifo_count;

  int n_cmp = 0;
  int n_mis = 0;

  fetch_prefetch_unit u_dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .instruction (instruction),
    .ins_pc      (ins_pc),
    .fifo_count  (fifo_count)
  );

  fetch_prefetch_unit #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (w_mem_req),
    .mem_addr    (w_mem_addr),
    .mem_ack     (w_mem_ack),
    .mem_rdata   (w_mem_rdata),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .ins_valid   (w_ins_valid),
    .ins_ready   (w_ins_ready),
    .instruction (w_instruction),
    .ins_pc      (w_ins_pc),
    .fifo_count  (w_fifo_count)
  );

  // Memory returns a word derived from its address.
  assign mem_rdata   = mem_addr ^ K;
  assign w_mem_rdata = w_mem_addr ^ K;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    mem_ack   = 1'b0;
    ins_ready = 1'b0;
    redirect  = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_count", fifo_count, 0);
    check("rst_valid", ins_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; mem_ack = 1'b0; ins_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    w_mem_ack = 1'b1; w_ins_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0;

    // Reset values while rst is held low.
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr", instruction, 0);
    check("rst_ins_pc", ins_pc, 0);
    check("rst_w_mem_addr", w_mem_addr, 32'hFFFFFFFC);
    do_reset();

    // First request at the first edge after release; then zero-wait streaming.
    @(negedge clk);
    check("start_req", mem_req, 1);
    check("start_addr", mem_addr, 0);
    mem_ack = 1'b1; ins_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      check("stream_valid", ins_valid, 1);
      check("stream_pc", ins_pc, 32'(4 * k));
      check("stream_instr", instruction, 32'(4 * k) ^ K);
      check("stream_addr", mem_addr, 32'(4 * (k + 1)));
      check("stream_count", fifo_count, 1);
      if (k == 0) begin
        check("wrap_pc0", w_ins_pc, 32'hFFFFFFFC);
        check("wrap_instr0", w_instruction, 32'h5A5A5A59);
        check("wrap_addr0", w_mem_addr, 32'h0);
      end
      if (k == 1) begin
        check("wrap_pc1", w_ins_pc, 32'h0);
        check("wrap_addr1", w_mem_addr, 32'h4);
        check("wrap_req1", w_mem_req, 1);
        check("wrap_valid1", w_ins_valid, 1);
        check("wrap_count1", w_fifo_count, 1);
      end
      @(negedge clk);
    end

    // Backpressure: reset mid-request, then fill the queue with ready low.
    do_reset();
    mem_ack = 1'b1;
    repeat (7) @(negedge clk);
    check("bp_count", fifo_count, 4);
    check("bp_req", mem_req, 0);
    check("bp_head", ins_pc, 0);
    ins_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("bp_drain_pc", ins_pc, 32'(4 * i));
      check("bp_drain_instr", instruction, 32'(4 * i) ^ K);
      if (i == 2) begin
        check("bp_resume_req", mem_req, 1);
        check("bp_resume_addr", mem_addr, 32'h10);
      end
      @(negedge clk);
    end

    // Wait states: ack three cycles after each request.
    do_reset();
    ins_ready = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 3; c++) begin
        check("ws_req", mem_req, 1);
        check("ws_addr", mem_addr, 32'(4 * w));
        if (c == 1) check("ws_no_dup", ins_valid, 0);
        if (c < 2) @(negedge clk);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("ws_valid", ins_valid, 1);
      check("ws_pc", ins_pc, 32'(4 * w));
      check("ws_instr", instruction, 32'(4 * w) ^ K);
    end

    // Redirect while the request for 0x8 is unacknowledged.
    do_reset();
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    check("rd_pre_count", fifo_count, 2);
    check("rd_pre_addr", mem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    check("rd_flush_count", fifo_count, 0);
    check("rd_flush_valid", ins_valid, 0);
    check("rd_drop_req", mem_req, 1);
    check("rd_drop_addr", mem_addr, 32'h8);
    @(negedge clk);
    check("rd_drop_hold", mem_addr, 32'h8);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("rd_discard_count", fifo_count, 0);
    check("rd_discard_valid", ins_valid, 0);
    check("rd_idle_req", mem_req, 0);
    @(negedge clk);
    check("rd_new_req", mem_req, 1);
    check("rd_new_addr", mem_addr, 32'h100);
    mem_ack = 1'b1;
    @(negedge clk);
    check("rd_first_pc", ins_pc, 32'h100);
    check("rd_first_instr", instruction, 32'h100 ^ K);
    @(negedge clk);
    mem_ack = 1'b0;
    check("sim_pre_count", fifo_count, 2);

    // Redirect and pop at the same edge with two entries queued.
    ins_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    ins_ready = 1'b0; redirect = 1'b0;
    check("sim_count", fifo_count, 0);
    check("sim_valid", ins_valid, 0);
    check("sim_drop_addr", mem_addr, 32'h108);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("sim_new_addr", mem_addr, 32'h200);
    check("sim_new_req", mem_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
